// File: rtl/var_delay_line_if.sv
// Pixel-stream bundle for var_delay_line: strobe, reconfig controls, sample in, delayed sample out.
// master drives samples and config; slave is the delay line.
interface var_delay_line_if #(
  parameter int WIDTH = 40,
  parameter int DW    = 5
);
  logic             en;
  logic             flush;
  logic [DW-1:0]    delay_sel;
  logic             valid_i;
  logic [WIDTH-1:0] data_i;
  logic             valid_o;
  logic [WIDTH-1:0] data_o;
  logic             primed;
  logic             cfg_err;

  modport master (
    output en, flush, delay_sel, valid_i, data_i,
    input  valid_o, data_o, primed, cfg_err
  );

  modport slave (
    input  en, flush, delay_sel, valid_i, data_i,
    output valid_o, data_o, primed, cfg_err
  );
endinterface

// File: rtl/var_delay_line.sv
// Programmable delay of a strobed pixel stream: latency d_cur+1 enabled edges, outputs registered.
// No backpressure; en=0 freezes the line, and any delay change or flush drops in-flight samples and re-primes.
module var_delay_line #(
  parameter int WIDTH     = 40,
  parameter int MAX_DEPTH = 16,
  parameter int DW        = 5
) (
  input logic           clk,
  input logic           reset,
  var_delay_line_if.slave bus
);
  localparam int CW = $clog2(MAX_DEPTH + 1);
  localparam int AW = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;
  localparam logic [DW-1:0] MAX_SEL = DW'(MAX_DEPTH);

  typedef enum logic {FILL, RUN} state_t;

  state_t           state;
  logic [CW-1:0]    d_cur;
  logic [CW-1:0]    fill_cnt;
  logic [AW-1:0]    wp;
  logic             valid_q;
  logic [WIDTH-1:0] data_q;
  logic             cfg_err_q;

  // Sample buffer carries the valid bit alongside the data; never reset.
  logic [WIDTH:0]   mem [MAX_DEPTH];

  logic             sel_over;
  logic [CW-1:0]    d_eff;
  logic             reconfig;
  logic             wr_en;
  logic [AW-1:0]    wp_nxt;
  logic [CW:0]      rd_sum;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH:0]   rd_word;

  assign sel_over = (bus.delay_sel > MAX_SEL);
  assign d_eff    = sel_over ? CW'(MAX_DEPTH) : CW'(bus.delay_sel);
  assign reconfig = bus.flush || (d_eff != d_cur);
  assign wr_en    = bus.en && !reconfig;
  assign wp_nxt   = (wp == AW'(MAX_DEPTH - 1)) ? '0 : wp + 1'b1;

  // Read address (wp - d_cur) mod MAX_DEPTH, kept non-negative by a bias of MAX_DEPTH.
  always_comb begin
    rd_sum = (CW+1)'(wp) + (CW+1)'(MAX_DEPTH) - (CW+1)'(d_cur);
    if (rd_sum >= (CW+1)'(MAX_DEPTH)) begin
      rd_sum = rd_sum - (CW+1)'(MAX_DEPTH);
    end
    rd_addr = AW'(rd_sum);
  end

  // Pre-write contents: with d_cur=MAX_DEPTH this is the entry about to be overwritten.
  assign rd_word = (d_cur == '0) ? {bus.valid_i, bus.data_i} : mem[rd_addr];

  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      mem[wp] <= {bus.valid_i, bus.data_i};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= FILL;
      d_cur     <= '0;
      fill_cnt  <= '0;
      wp        <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= sel_over;
      if (reconfig) begin
        d_cur    <= d_eff;
        state    <= FILL;
        fill_cnt <= '0;
        valid_q  <= 1'b0;
        data_q   <= '0;
      end else if (bus.en) begin
        wp <= wp_nxt;
        if (state == RUN || fill_cnt == d_cur) begin
          state   <= RUN;
          valid_q <= rd_word[WIDTH];
          data_q  <= rd_word[WIDTH-1:0];
        end else begin
          fill_cnt <= fill_cnt + 1'b1;
          valid_q  <= 1'b0;
          data_q   <= '0;
        end
      end
    end
  end

  assign bus.valid_o = valid_q;
  assign bus.data_o  = data_q;
  assign bus.primed  = (state == RUN);
  assign bus.cfg_err = cfg_err_q;
endmodule

// File: tb/tb_var_delay_line.sv
// Directed stimulus for var_delay_line; expected samples are queued by the driver and consumed by a monitor.
module tb_var_delay_line;
  localparam int WIDTH     = 40;
  localparam int MAX_DEPTH = 16;
  localparam int DW        = 5;

  logic clk;
  logic reset;

  var_delay_line_if #(.WIDTH(WIDTH), .DW(DW)) bus();

  var_delay_line #(.WIDTH(WIDTH), .MAX_DEPTH(MAX_DEPTH), .DW(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [WIDTH-1:0] exp_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, expv);
    end
  endtask

  // Inputs change on the falling edge; the following rising edge consumes them.
  task automatic step(input logic e, input logic f, input logic [DW-1:0] ds,
                      input logic v, input logic [WIDTH-1:0] d);
    bus.en        = e;
    bus.flush     = f;
    bus.delay_sel = ds;
    bus.valid_i   = v;
    bus.data_i    = d;
    @(negedge clk);
  endtask

  task automatic push_range(input int a, input int b);
    for (int k = a; k <= b; k++) exp_q.push_back(WIDTH'(k));
  endtask

  task automatic send_range(input int a, input int b, input logic [DW-1:0] ds);
    for (int k = a; k <= b; k++) step(1'b1, 1'b0, ds, 1'b1, WIDTH'(k));
  endtask

  // Monitor: every enabled edge that presents valid_o=1 must match the head of the queue.
  initial begin : monitor
    logic en_s;
    logic rst_s;
    logic [WIDTH-1:0] e;
    forever begin
      @(posedge clk);
      en_s  = bus.en;
      rst_s = reset;
      #1;
      if (!rst_s && !reset && en_s && bus.valid_o) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: got %0h want none", bus.data_o);
        end else begin
          e = exp_q.pop_front();
          chk("scoreboard_data", 64'(bus.data_o), 64'(e));
        end
      end
    end
  end

  initial begin
    reset         = 1'b1;
    bus.en        = 1'b0;
    bus.flush     = 1'b0;
    bus.delay_sel = 5'd5;
    bus.valid_i   = 1'b0;
    bus.data_i    = '0;
    repeat (2) @(negedge clk);
    chk("reset_valid_o", 64'(bus.valid_o), 64'd0);
    chk("reset_data_o",  64'(bus.data_o),  64'd0);
    chk("reset_primed",  64'(bus.primed),  64'd0);
    chk("reset_cfg_err", 64'(bus.cfg_err), 64'd0);
    reset = 1'b0;

    // D=5 ramp: five masked edges, then 1,2,3... back to back.
    push_range(1, 15);
    step(1'b1, 1'b0, 5'd5, 1'b1, 40'hAA);
    chk("d5_primed_after_reconfig", 64'(bus.primed), 64'd0);
    for (int k = 1; k <= 20; k++) begin
      step(1'b1, 1'b0, 5'd5, 1'b1, WIDTH'(k));
      if (k == 5) begin
        chk("d5_primed_fill", 64'(bus.primed),  64'd0);
        chk("d5_valid_fill",  64'(bus.valid_o), 64'd0);
      end
      if (k == 6) chk("d5_primed_run", 64'(bus.primed), 64'd1);
    end
    chk("d5_queue_drained", 64'(exp_q.size()), 64'd0);

    // D=0 is a single register stage.
    push_range(101, 110);
    step(1'b1, 1'b0, 5'd0, 1'b1, 40'hBB);
    send_range(101, 110, 5'd0);
    chk("d0_queue_drained", 64'(exp_q.size()), 64'd0);

    // D=MAX_DEPTH reads the slot being overwritten; 100 samples wrap the buffer several times.
    push_range(1000, 1083);
    step(1'b1, 1'b0, 5'd16, 1'b1, 40'hCC);
    send_range(1000, 1099, 5'd16);
    chk("d16_queue_drained", 64'(exp_q.size()), 64'd0);
    chk("d16_cfg_err",       64'(bus.cfg_err),  64'd0);

    // D=3 with en toggling: same sequence, outputs held across en=0 edges.
    push_range(201, 209);
    step(1'b1, 1'b0, 5'd3, 1'b1, 40'hDD);
    for (int k = 1; k <= 12; k++) begin
      step(1'b1, 1'b0, 5'd3, 1'b1, WIDTH'(200 + k));
      step(1'b0, 1'b0, 5'd3, 1'b1, 40'hDEAD);
      if (k >= 4) begin
        chk("d3_hold_valid", 64'(bus.valid_o), 64'd1);
        chk("d3_hold_data",  64'(bus.data_o),  64'(200 + k - 3));
      end
    end
    chk("d3_queue_drained", 64'(exp_q.size()), 64'd0);

    // D=4 -> 2 mid-stream: 311 dropped, resume at 3-edge latency.
    push_range(301, 306);
    step(1'b1, 1'b0, 5'd4, 1'b1, 40'hEE);
    send_range(301, 310, 5'd4);
    push_range(312, 318);
    step(1'b1, 1'b0, 5'd2, 1'b1, WIDTH'(311));
    chk("d4to2_valid_after_change", 64'(bus.valid_o), 64'd0);
    send_range(312, 320, 5'd2);
    chk("d4to2_queue_drained", 64'(exp_q.size()), 64'd0);

    // Flush pulse at D=2: same drop and re-prime.
    push_range(322, 328);
    step(1'b1, 1'b1, 5'd2, 1'b1, WIDTH'(321));
    chk("flush_valid_after", 64'(bus.valid_o), 64'd0);
    send_range(322, 330, 5'd2);
    chk("flush_queue_drained", 64'(exp_q.size()), 64'd0);

    // Over-range select clamps to MAX_DEPTH; moving 20 -> 16 is not a reconfig.
    push_range(401, 404);
    step(1'b1, 1'b0, 5'd20, 1'b1, 40'hFF);
    chk("clamp_cfg_err_set", 64'(bus.cfg_err), 64'd1);
    send_range(401, 420, 5'd20);
    chk("clamp_cfg_err_held", 64'(bus.cfg_err), 64'd1);
    push_range(405, 409);
    send_range(421, 425, 5'd16);
    chk("clamp_cfg_err_clear", 64'(bus.cfg_err), 64'd0);
    chk("clamp_primed",        64'(bus.primed),  64'd1);
    chk("clamp_queue_drained", 64'(exp_q.size()), 64'd0);

    // Mid-stream reset clears outputs asynchronously, then re-prime at D=5.
    reset = 1'b1;
    #1;
    chk("midrst_valid_o", 64'(bus.valid_o), 64'd0);
    chk("midrst_data_o",  64'(bus.data_o),  64'd0);
    chk("midrst_primed",  64'(bus.primed),  64'd0);
    @(negedge clk);
    reset = 1'b0;
    push_range(501, 515);
    step(1'b1, 1'b0, 5'd5, 1'b1, 40'hAB);
    for (int k = 1; k <= 20; k++) begin
      step(1'b1, 1'b0, 5'd5, 1'b1, WIDTH'(500 + k));
      if (k == 5) chk("reprime_valid_fill", 64'(bus.valid_o), 64'd0);
    end
    chk("reprime_primed",        64'(bus.primed),  64'd1);
    chk("reprime_queue_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/var_delay_line.md
VAR_DELAY_LINE -- requirements
Module: var_delay_line

Interface
REQ-001 SHALL have parameter WIDTH, default 40: data bits per sample (one TMDS-aligned pixel word).
REQ-002 SHALL have parameter MAX_DEPTH, default 16: maximum delay in enabled cycles; legal range 1..256.
REQ-003 SHALL have parameter DW, default 5: width of delay_sel; must be at least clog2(MAX_DEPTH+1).
REQ-004 SHALL have port clk  input  1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1: asynchronous, active-high reset.
REQ-006 SHALL have port en  input  1: pixel strobe; the line advances only on edges where en=1.
REQ-007 SHALL have port flush  input  1: synchronous request to discard buffered samples and re-prime.
REQ-008 SHALL have port delay_sel  input  DW: requested delay D in enabled cycles.
REQ-009 SHALL have port valid_i  input  1: data_i qualifier.
REQ-010 SHALL have port data_i  input  WIDTH: sample to delay.
REQ-011 SHALL have port valid_o  output  1: registered data_o qualifier.
REQ-012 SHALL have port data_o  output  WIDTH: registered delayed sample.
REQ-013 SHALL have port primed  output  1: high in state RUN.
REQ-014 SHALL have port cfg_err  output  1: registered; high while delay_sel > MAX_DEPTH.

Function
REQ-015 SHALL compute D_eff = min(delay_sel, MAX_DEPTH) combinationally and hold the active delay in register d_cur.
REQ-016 SHALL store {valid_i, data_i} in a circular buffer of MAX_DEPTH entries with write pointer wp wrapping MAX_DEPTH-1 -> 0.
REQ-017 SHALL treat an edge as a reconfig edge when flush=1 or D_eff != d_cur; reconfig has priority over en.
REQ-018 On a reconfig edge: d_cur <= D_eff, state <= FILL, fill_cnt <= 0, valid_o <= 0, data_o <= 0, no write, the input sample is dropped, wp unchanged.
REQ-019 On a non-reconfig edge with en=1: write mem[wp], then increment wp.
REQ-020 On the same edge, the read SHALL use the pre-write contents: if d_cur=0, output <= {valid_i, data_i}; else output <= mem[(wp - d_cur) mod MAX_DEPTH].
REQ-021 Latency SHALL be d_cur+1 enabled edges from sampling to visibility at data_o; d_cur=MAX_DEPTH reads the entry being overwritten, using its old value.
REQ-022 State FILL: on each en edge, fill_cnt++ and valid_o <= 0, data_o <= 0; on the en edge where fill_cnt == d_cur, state <= RUN and the read of REQ-020 is output normally.
REQ-023 State RUN: every en edge performs REQ-019/020; valid_o follows the stored valid bit.
REQ-024 SHALL hold all registers and outputs on edges with en=0 and no reconfig.
REQ-025 fill_cnt SHALL be clog2(MAX_DEPTH+1) bits wide and never exceed d_cur.
REQ-026 Buffer contents SHALL NOT be reset; FILL masking guarantees stale entries never reach valid_o=1.

Reset
REQ-027 When reset is high: valid_o=0, data_o=0, primed=0, cfg_err=0, state=FILL, d_cur=0, fill_cnt=0, wp=0.
REQ-028 After release, a nonzero delay_sel SHALL be taken up through a reconfig on the first edge.
REQ-029 Reset asserted mid-stream SHALL discard all in-flight samples; no valid_o=1 until re-primed.

Verification
REQ-030 WIDTH=40, MAX_DEPTH=16, delay_sel=5, en=1, ramp data_i=1,2,3... valid_i=1 -> after reconfig, valid_o=0 for 5 edges; then data_o=1 with valid_o=1, consecutive thereafter; primed=1.
REQ-031 delay_sel=0 -> data_o equals data_i from the previous edge (1-cycle latency); delay_sel=16 -> 17-edge latency with wrap correct over 100 samples.
REQ-032 en toggling 1,0,1,0 with D=3 -> output sequence identical to continuous en; values held during en=0.
REQ-033 In RUN with D=4, change delay_sel to 2 -> one sample dropped, valid_o=0 for 2 en edges, then samples resume at 3-edge latency; the same holds for a flush pulse.
REQ-034 delay_sel=20 with MAX_DEPTH=16 -> cfg_err=1; behaves as D=16.
REQ-035 Assert reset mid-stream for 1 cycle -> all outputs 0 immediately; re-prime matches REQ-030.
